// File: rtl/nn_layer_tdm.sv
// Time-multiplexed fully-connected layer: one shared MAC walks every neuron
// over a buffered input vector, then applies bias, saturation and optional ReLU.
module nn_layer_tdm #(
    parameter int NN               = 10,
    parameter int NUM_WEIGHT       = 784,
    parameter int DATA_WIDTH       = 16,
    parameter int WEIGHT_INT_WIDTH = 4,
    parameter int ACT_RELU         = 1,
    localparam int IDX_W = (NN > 1) ? $clog2(NN) : 1,
    localparam int WA_W  = (NN * NUM_WEIGHT > 1) ? $clog2(NN * NUM_WEIGHT) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wt_we,
    input  logic [WA_W-1:0]       wt_addr,
    input  logic [DATA_WIDTH-1:0] wt_data,
    input  logic                  bias_we,
    input  logic [IDX_W-1:0]      bias_addr,
    input  logic [DATA_WIDTH-1:0] bias_data,
    input  logic                  x_valid,
    output logic                  x_ready,
    input  logic [DATA_WIDTH-1:0] x_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [IDX_W-1:0]      out_idx,
    output logic                  out_last,
    output logic                  out_sat,
    output logic [1:0]            dbg_state
);

    localparam int FRAC   = DATA_WIDTH - WEIGHT_INT_WIDTH;
    localparam int CNT_W  = $clog2(NUM_WEIGHT);
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int ACC_W  = PROD_W + CNT_W;
    localparam int SUM_W  = ACC_W + 1;

    localparam logic [1:0] S_LOAD    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_FINAL   = 2'd2;
    localparam logic [1:0] S_OUT     = 2'd3;

    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [1:0]               state_q, state_d;
    logic [CNT_W-1:0]         in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]         w_cnt_q, w_cnt_d;
    logic [IDX_W-1:0]         neuron_q, neuron_d;
    logic                     fin_ph_q, fin_ph_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [PROD_W-1:0] prod_q, prod_d;
    logic                     prod_vld_q, prod_vld_d;
    logic                     out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
    logic [IDX_W-1:0]         out_idx_q, out_idx_d;
    logic                     out_last_q, out_last_d;
    logic                     out_sat_q, out_sat_d;
    logic                     rdy_en_q, rdy_en_d;

    // Storage is deliberately outside the reset domain so a reset keeps the model.
    logic signed [DATA_WIDTH-1:0] x_buf [NUM_WEIGHT];
    logic signed [DATA_WIDTH-1:0] w_mem [NN*NUM_WEIGHT];
    logic signed [DATA_WIDTH-1:0] b_mem [NN];

    logic                         x_fire;
    logic                         wt_wr_ok;
    logic                         bias_wr_ok;
    logic [WA_W-1:0]              w_rd_addr;
    logic signed [DATA_WIDTH-1:0] b_rd;
    logic signed [ACC_W-1:0]      prod_ext;
    logic signed [ACC_W-1:0]      acc_plus;
    logic signed [SUM_W-1:0]      bias_ext;
    logic signed [SUM_W-1:0]      biased;
    logic signed [SUM_W-1:0]      shifted;
    logic                         ovf;
    logic [DATA_WIDTH-1:0]        sat_val;
    logic [DATA_WIDTH-1:0]        act_val;

    // Handshakes: a beat transfers on a rising edge where valid and ready are both
    // high; the producer holds its payload steady while valid is high and ready low.
    assign x_ready    = rdy_en_q && (state_q == S_LOAD);
    assign x_fire     = x_valid && x_ready;
    assign wt_wr_ok   = wt_we && (state_q == S_LOAD) && (32'(wt_addr) < NN * NUM_WEIGHT);
    assign bias_wr_ok = bias_we && (state_q == S_LOAD) && (32'(bias_addr) < NN);

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign out_sat   = out_sat_q;
    assign dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (x_fire) begin
            x_buf[in_cnt_q] <= x_in;
        end
        if (wt_wr_ok) begin
            w_mem[wt_addr] <= wt_data;
        end
        if (bias_wr_ok) begin
            b_mem[bias_addr] <= bias_data;
        end
    end

    always_comb begin
        w_rd_addr = WA_W'(int'(neuron_q) * NUM_WEIGHT + int'(w_cnt_q));
        b_rd      = b_mem[neuron_q];
        prod_ext  = ACC_W'(prod_q);
        acc_plus  = acc_q + prod_ext;
        bias_ext  = SUM_W'(b_rd) <<< FRAC;
        biased    = SUM_W'(acc_q) + bias_ext;
        shifted   = biased >>> FRAC;
        ovf       = (shifted[SUM_W-1:DATA_WIDTH-1] != {(SUM_W-DATA_WIDTH+1){shifted[SUM_W-1]}});
        if (ovf) begin
            sat_val = shifted[SUM_W-1] ? SAT_MIN : SAT_MAX;
        end else begin
            sat_val = shifted[DATA_WIDTH-1:0];
        end
        act_val = sat_val;
        if ((ACT_RELU != 0) && sat_val[DATA_WIDTH-1]) begin
            act_val = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        w_cnt_d     = w_cnt_q;
        neuron_d    = neuron_q;
        fin_ph_d    = fin_ph_q;
        acc_d       = acc_q;
        prod_d      = prod_q;
        prod_vld_d  = prod_vld_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        out_sat_d   = out_sat_q;
        rdy_en_d    = 1'b1;

        case (state_q)
            S_LOAD: begin
                if (x_fire) begin
                    if (in_cnt_q == CNT_W'(NUM_WEIGHT - 1)) begin
                        in_cnt_d   = '0;
                        state_d    = S_COMPUTE;
                        neuron_d   = '0;
                        w_cnt_d    = '0;
                        acc_d      = '0;
                        prod_vld_d = 1'b0;
                    end else begin
                        in_cnt_d = in_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_COMPUTE: begin
                // Products are registered; the accumulator trails the multiplier by one cycle.
                prod_d     = PROD_W'(x_buf[w_cnt_q]) * PROD_W'(w_mem[w_rd_addr]);
                prod_vld_d = 1'b1;
                if (prod_vld_q) begin
                    acc_d = acc_plus;
                end
                if (w_cnt_q == CNT_W'(NUM_WEIGHT - 1)) begin
                    w_cnt_d  = '0;
                    fin_ph_d = 1'b0;
                    state_d  = S_FINAL;
                end else begin
                    w_cnt_d = w_cnt_q + CNT_W'(1);
                end
            end
            S_FINAL: begin
                if (!fin_ph_q) begin
                    acc_d      = acc_plus;
                    prod_vld_d = 1'b0;
                    fin_ph_d   = 1'b1;
                end else begin
                    out_data_d  = act_val;
                    out_sat_d   = ovf;
                    out_idx_d   = neuron_q;
                    out_last_d  = (neuron_q == IDX_W'(NN - 1));
                    out_valid_d = 1'b1;
                    fin_ph_d    = 1'b0;
                    state_d     = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (neuron_q == IDX_W'(NN - 1)) begin
                        in_cnt_d = '0;
                        state_d  = S_LOAD;
                    end else begin
                        neuron_d   = neuron_q + IDX_W'(1);
                        w_cnt_d    = '0;
                        acc_d      = '0;
                        prod_vld_d = 1'b0;
                        state_d    = S_COMPUTE;
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_LOAD;
            in_cnt_q    <= '0;
            w_cnt_q     <= '0;
            neuron_q    <= '0;
            fin_ph_q    <= 1'b0;
            acc_q       <= '0;
            prod_q      <= '0;
            prod_vld_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            out_sat_q   <= 1'b0;
            rdy_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            w_cnt_q     <= w_cnt_d;
            neuron_q    <= neuron_d;
            fin_ph_q    <= fin_ph_d;
            acc_q       <= acc_d;
            prod_q      <= prod_d;
            prod_vld_q  <= prod_vld_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            out_sat_q   <= out_sat_d;
            rdy_en_q    <= rdy_en_d;
        end
    end

endmodule

// File: tb/tb_nn_layer_tdm.sv
// Directed bench for nn_layer_tdm (3 neurons x 4 inputs, Q4.12), checking a ReLU
// instance and an identity instance driven by the same stimulus.
module tb_nn_layer_tdm;

    localparam logic [1:0] S_LOAD    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_OUT     = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        wt_we;
    logic [3:0]  wt_addr;
    logic [15:0] wt_data;
    logic        bias_we;
    logic [1:0]  bias_addr;
    logic [15:0] bias_data;
    logic        x_valid;
    logic [15:0] x_in;
    logic        out_ready;

    logic        x_ready, out_valid, out_last, out_sat;
    logic [15:0] out_data;
    logic [1:0]  out_idx, dbg_state;
    logic        x_ready_i, out_valid_i, out_last_i, out_sat_i;
    logic [15:0] out_data_i;
    logic [1:0]  out_idx_i, dbg_state_i;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] w;
        logic [15:0] x;
        logic [15:0] b;
        logic [15:0] exp_relu;
        logic [15:0] exp_id;
        logic        exp_sat;
    } vec_t;

    vec_t vecs [7];

    nn_layer_tdm #(.NN(3), .NUM_WEIGHT(4), .DATA_WIDTH(16), .WEIGHT_INT_WIDTH(4), .ACT_RELU(1)) dut (
        .clk(clk), .rst(rst),
        .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
        .bias_we(bias_we), .bias_addr(bias_addr), .bias_data(bias_data),
        .x_valid(x_valid), .x_ready(x_ready), .x_in(x_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .out_sat(out_sat),
        .dbg_state(dbg_state)
    );

    nn_layer_tdm #(.NN(3), .NUM_WEIGHT(4), .DATA_WIDTH(16), .WEIGHT_INT_WIDTH(4), .ACT_RELU(0)) dut_id (
        .clk(clk), .rst(rst),
        .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
        .bias_we(bias_we), .bias_addr(bias_addr), .bias_data(bias_data),
        .x_valid(x_valid), .x_ready(x_ready_i), .x_in(x_in),
        .out_valid(out_valid_i), .out_ready(out_ready), .out_data(out_data_i),
        .out_idx(out_idx_i), .out_last(out_last_i), .out_sat(out_sat_i),
        .dbg_state(dbg_state_i)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic write_model(input logic [15:0] wv [12], input logic [15:0] bv [3]);
        for (int a = 0; a < 12; a++) begin
            wt_we = 1'b1; wt_addr = 4'(a); wt_data = wv[a];
            @(negedge clk);
        end
        wt_we = 1'b0;
        for (int n = 0; n < 3; n++) begin
            bias_we = 1'b1; bias_addr = 2'(n); bias_data = bv[n];
            @(negedge clk);
        end
        bias_we = 1'b0;
    endtask

    // Leaves the last beat presented; the next clock edge transfers it.
    task automatic send_vector(input logic [15:0] xv [4]);
        int guard;
        for (int i = 0; i < 4; i++) begin
            guard = 0;
            while (!x_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (!x_ready) check("x_ready_timeout", {31'd0, x_ready}, 32'd1);
            x_valid = 1'b1;
            x_in = xv[i];
            if (i < 3) @(negedge clk);
        end
    endtask

    task automatic wait_valid(output int cyc);
        logic busy_ready;
        cyc = 0;
        busy_ready = 1'b0;
        do begin
            @(negedge clk);
            x_valid = 1'b0;
            cyc++;
            if (!out_valid && x_ready) busy_ready = 1'b1;
        end while (!out_valid && cyc < 60);
        check("valid_seen", {31'd0, out_valid}, 32'd1);
        check("x_ready_busy", {31'd0, busy_ready}, 32'd0);
    endtask

    task automatic collect(input string tag, input logic [15:0] er [3], input logic [15:0] ei [3],
                           input logic es [3], input int lat0);
        int lat;
        for (int n = 0; n < 3; n++) begin
            wait_valid(lat);
            check($sformatf("%s_n%0d_lat", tag, n), lat, (n == 0) ? lat0 : 7);
            check($sformatf("%s_n%0d_valid_id", tag, n), {31'd0, out_valid_i}, 32'd1);
            check($sformatf("%s_n%0d_data", tag, n), {16'd0, out_data}, {16'd0, er[n]});
            check($sformatf("%s_n%0d_data_id", tag, n), {16'd0, out_data_i}, {16'd0, ei[n]});
            check($sformatf("%s_n%0d_idx", tag, n), {30'd0, out_idx}, n);
            check($sformatf("%s_n%0d_last", tag, n), {31'd0, out_last}, (n == 2) ? 32'd1 : 32'd0);
            check($sformatf("%s_n%0d_sat", tag, n), {31'd0, out_sat}, {31'd0, es[n]});
            check($sformatf("%s_n%0d_sat_id", tag, n), {31'd0, out_sat_i}, {31'd0, es[n]});
        end
        @(negedge clk);
    endtask

    task automatic uniform_model(input logic [15:0] w, input logic [15:0] b);
        logic [15:0] wv [12];
        logic [15:0] bv [3];
        for (int a = 0; a < 12; a++) wv[a] = w;
        for (int n = 0; n < 3; n++) bv[n] = b;
        write_model(wv, bv);
    endtask

    task automatic uniform_vector(input logic [15:0] x);
        logic [15:0] xv [4];
        for (int i = 0; i < 4; i++) xv[i] = x;
        send_vector(xv);
    endtask

    initial begin
        logic [15:0] er [3];
        logic [15:0] ei [3];
        logic        es [3];
        logic [15:0] wv [12];
        logic [15:0] bv [3];
        logic [15:0] xv [4];
        int          lat;

        vecs[0] = '{16'h1000, 16'h0800, 16'h0400, 16'h2400, 16'h2400, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1};
        vecs[2] = '{16'hF000, 16'h1000, 16'h0000, 16'h0000, 16'hC000, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h8000, 16'h8000, 16'h0000, 16'h8000, 1'b1};
        vecs[4] = '{16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 1'b0};
        vecs[5] = '{16'h0400, 16'h0003, 16'h0001, 16'h0004, 16'h0004, 1'b0};
        vecs[6] = '{16'hF000, 16'h1000, 16'h7000, 16'h3000, 16'h3000, 1'b0};

        rst = 1'b0;
        wt_we = 1'b0; wt_addr = '0; wt_data = '0;
        bias_we = 1'b0; bias_addr = '0; bias_data = '0;
        x_valid = 1'b0; x_in = '0;
        out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_x_ready", {31'd0, x_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {16'd0, out_data}, 32'd0);
        check("rst_out_idx", {30'd0, out_idx}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_out_sat", {31'd0, out_sat}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, {30'd0, S_LOAD});
        rst = 1'b1;
        @(negedge clk);
        check("rel_x_ready", {31'd0, x_ready}, 32'd1);

        for (int e = 0; e < 7; e++) begin
            uniform_model(vecs[e].w, vecs[e].b);
            uniform_vector(vecs[e].x);
            for (int n = 0; n < 3; n++) begin
                er[n] = vecs[e].exp_relu;
                ei[n] = vecs[e].exp_id;
                es[n] = vecs[e].exp_sat;
            end
            collect($sformatf("vec%0d", e), er, ei, es, 7);
        end

        // Distinct weights per neuron: exercises weight addressing, bias addressing and input order.
        for (int a = 0; a < 12; a++) wv[a] = 16'h0000;
        wv[0] = 16'h1000;
        wv[5] = 16'h1000;
        wv[11] = 16'h1000;
        bv[0] = 16'h0100; bv[1] = 16'hFF00; bv[2] = 16'h0000;
        xv[0] = 16'h1000; xv[1] = 16'h2000; xv[2] = 16'h7FFF; xv[3] = 16'hF000;
        write_model(wv, bv);
        send_vector(xv);
        er[0] = 16'h1100; er[1] = 16'h1F00; er[2] = 16'h0000;
        ei[0] = 16'h1100; ei[1] = 16'h1F00; ei[2] = 16'hF000;
        es[0] = 1'b0; es[1] = 1'b0; es[2] = 1'b0;
        collect("addr", er, ei, es, 7);

        // Back-pressure on neuron 1.
        uniform_model(16'h1000, 16'h0400);
        uniform_vector(16'h0800);
        wait_valid(lat);
        check("bp_n0_lat", lat, 7);
        check("bp_n0_idx", {30'd0, out_idx}, 32'd0);
        wait_valid(lat);
        check("bp_n1_lat", lat, 7);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d_valid", k), {31'd0, out_valid}, 32'd1);
            check($sformatf("bp_hold%0d_data", k), {16'd0, out_data}, 32'h2400);
            check($sformatf("bp_hold%0d_idx", k), {30'd0, out_idx}, 32'd1);
            check($sformatf("bp_hold%0d_last", k), {31'd0, out_last}, 32'd0);
            check($sformatf("bp_hold%0d_sat", k), {31'd0, out_sat}, 32'd0);
            check($sformatf("bp_hold%0d_x_ready", k), {31'd0, x_ready}, 32'd0);
            check($sformatf("bp_hold%0d_state", k), {30'd0, dbg_state}, {30'd0, S_OUT});
        end
        out_ready = 1'b1;
        wait_valid(lat);
        check("bp_n2_lat", lat, 7);
        check("bp_n2_idx", {30'd0, out_idx}, 32'd2);
        check("bp_n2_data", {16'd0, out_data}, 32'h2400);
        check("bp_n2_last", {31'd0, out_last}, 32'd1);
        @(negedge clk);

        // Reset while neuron 1 is computing, then reload with the retained model.
        uniform_vector(16'h0800);
        wait_valid(lat);
        check("rc_n0_data", {16'd0, out_data}, 32'h2400);
        @(negedge clk);
        @(negedge clk);
        check("rc_pre_state", {30'd0, dbg_state}, {30'd0, S_COMPUTE});
        rst = 1'b0;
        #1;
        check("rc_out_valid", {31'd0, out_valid}, 32'd0);
        check("rc_out_data", {16'd0, out_data}, 32'd0);
        check("rc_out_idx", {30'd0, out_idx}, 32'd0);
        check("rc_out_last", {31'd0, out_last}, 32'd0);
        check("rc_state", {30'd0, dbg_state}, {30'd0, S_LOAD});
        check("rc_x_ready", {31'd0, x_ready}, 32'd0);
        @(negedge clk);
        check("rc_x_ready_held", {31'd0, x_ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rc_x_ready_rel", {31'd0, x_ready}, 32'd1);
        uniform_vector(16'h0800);
        for (int n = 0; n < 3; n++) begin
            er[n] = 16'h2400; ei[n] = 16'h2400; es[n] = 1'b0;
        end
        collect("rst_reload", er, ei, es, 7);

        // Weight and bias writes attempted during computation must be dropped.
        uniform_vector(16'h0800);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            x_valid = 1'b0;
            wt_we = 1'b1; wt_addr = 4'(4 + k); wt_data = 16'h7FFF;
            bias_we = 1'b1; bias_addr = 2'(k % 3); bias_data = 16'h7FFF;
        end
        @(negedge clk);
        wt_we = 1'b0;
        bias_we = 1'b0;
        collect("wt_lock", er, ei, es, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/nn_layer_tdm.md
NN_LAYER_TDM -- requirements
Module: nn_layer_tdm

Interface
REQ-001 SHALL have parameter NN, default 10: number of neurons in the layer.
REQ-002 SHALL have parameter NUM_WEIGHT, default 784: inputs per neuron (≥2).
REQ-003 SHALL have parameter DATA_WIDTH, default 16: width of data, weight and bias words.
REQ-004 SHALL have parameter WEIGHT_INT_WIDTH, default 4: integer bits including sign; FRAC = DATA_WIDTH-WEIGHT_INT_WIDTH.
REQ-005 SHALL have parameter ACT_RELU, default 1: 1 = ReLU, 0 = identity.
REQ-006 SHALL have ports: clk  in  1  clock, all logic rising-edge.
REQ-007 SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-008 SHALL have ports: wt_we  in  1; wt_addr  in  clog2(NN*NUM_WEIGHT)  (neuron*NUM_WEIGHT+index); wt_data  in  DATA_WIDTH.
REQ-009 SHALL have ports: bias_we  in  1; bias_addr  in  clog2(NN); bias_data  in  DATA_WIDTH.
REQ-010 SHALL have ports: x_valid  in  1; x_ready  out  1; x_in  in  DATA_WIDTH  (input vector, element order 0..NUM_WEIGHT-1).
REQ-011 SHALL have ports: out_valid  out  1; out_ready  in  1; out_data  out  DATA_WIDTH; out_idx  out  clog2(NN); out_last  out  1; out_sat  out  1.

Function
REQ-012 SHALL be an FSM with states LOAD, COMPUTE, FINAL, OUT; reset state LOAD.
REQ-013 LOAD: x_ready=1; each x_valid&x_ready beat writes x_in to input buffer[in_cnt], in_cnt++.
REQ-014 Beat with in_cnt=NUM_WEIGHT-1 SHALL move to COMPUTE for neuron 0 next cycle; x_ready=0 outside LOAD.
REQ-015 Weight/bias writes SHALL be honored only in LOAD; writes in other states ignored.
REQ-016 All data, weights and biases SHALL be signed two's complement with FRAC fraction bits.
REQ-017 COMPUTE SHALL accumulate sum over i of x[i]*w[n][i], one product per cycle, into accumulator of 2*DATA_WIDTH+clog2(NUM_WEIGHT) bits; no internal overflow or wrap.
REQ-018 FINAL SHALL add bias sign-extended and shifted left FRAC, arithmetic-shift result right FRAC (truncate toward -inf), saturate to DATA_WIDTH signed range.
REQ-019 out_sat SHALL be 1 when saturation clipped the value, else 0.
REQ-020 When ACT_RELU=1, a negative post-saturation value SHALL become 0; out_sat unaffected by ReLU.
REQ-021 out_valid SHALL rise exactly NUM_WEIGHT+2 cycles after COMPUTE entry for each neuron.
REQ-022 While out_valid=1 and out_ready=0, out_data, out_idx, out_last, out_sat SHALL stay stable; no further computation.
REQ-023 On out_valid&out_ready: if out_idx<NN-1, go to COMPUTE for out_idx+1 next cycle; else return to LOAD (in_cnt=0).
REQ-024 out_idx SHALL equal neuron number; out_last=1 only for neuron NN-1.
REQ-025 Input buffer, weights and biases SHALL be retained across vectors; each vector is fully reloaded before compute.
REQ-026 Sustained throughput: one vector per NUM_WEIGHT + NN*(NUM_WEIGHT+3) cycles with out_ready tied high.

Reset
REQ-027 rst low SHALL immediately force state LOAD, in_cnt=0, accumulator=0, out_valid=0, out_data=0, out_idx=0, out_last=0, out_sat=0, x_ready=0 while rst low and 1 from first clock after release.
REQ-028 Reset SHALL NOT clear weight, bias or input-buffer storage; mid-operation reset abandons the current vector.

Verification (NN=3, NUM_WEIGHT=4, DATA_WIDTH=16, WEIGHT_INT_WIDTH=4)
REQ-029 All weights 0x1000, inputs 4×0x0800, biases 0x0400, out_ready=1 -> three outputs 0x2400, idx 0,1,2, out_last only on idx 2, out_sat=0, each out_valid 6 cycles after COMPUTE entry.
REQ-030 Weights and inputs 0x7FFF, bias 0x7FFF -> out_data 0x7FFF, out_sat=1 for all neurons.
REQ-031 Weights 0xF000, inputs 0x1000, bias 0 -> ACT_RELU=1 gives 0x0000, out_sat=0; ACT_RELU=0 gives 0xC000.
REQ-032 out_ready low 5 cycles on neuron 1 -> outputs stable, neuron 2 not started, x_ready stays 0; release -> neuron 2 result 6 cycles after handshake+1.
REQ-033 rst low during COMPUTE of neuron 1 -> out_valid=0 immediately; reload vector -> outputs match REQ-029 values with stored weights.
REQ-034 wt_we pulses during COMPUTE -> weights unchanged, results identical to REQ-029.
